// File: rtl/arm_mul_seq_pkg.sv
// Shared types and opcode helpers for the multiply sequencer.
// Opcode encodings 6 and 7 are unused and decode as illegal.
package arm_mul_seq_pkg;

  typedef enum logic [2:0] {
    MUL   = 3'd0,
    MLA   = 3'd1,
    UMULL = 3'd2,
    UMLAL = 3'd3,
    SMULL = 3'd4,
    SMLAL = 3'd5
  } mul_op_t;

  typedef enum logic [3:0] {
    IDLE, SHORT, PP0, PP1, PP2, PP3, FIN, WB_LO, WB_HI
  } mul_state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic is_long(input logic [2:0] op);
    return (op == UMULL) || (op == UMLAL) || (op == SMULL) || (op == SMLAL);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MLA) || (op == UMLAL) || (op == SMLAL);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == SMULL) || (op == SMLAL);
  endfunction

  // Unsigned magnitude; 0x80000000 maps to itself, which is exact as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/arm_mul_seq_if.sv
// Request, shared-MAC and writeback signals of the multiply sequencer.
// The slave side is the sequencer; the master side is the decode/MAC/regfile environment.
interface arm_mul_seq_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_s;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc_lo;
  logic [31:0] acc_hi;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic [31:0] mac_op1;
  logic [31:0] mac_op2;
  logic [31:0] mac_acc;
  logic        mac_sel;
  logic        alu_or_mac;
  logic [31:0] mac_out;
  logic        stall;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flag_we;
  logic [1:0]  flag_nz;

  modport slave (
    input  flush, req_valid, req_op, req_s, op_a, op_b, acc_lo, acc_hi,
           rd_lo, rd_hi, mac_out,
    output req_ready, mac_op1, mac_op2, mac_acc, mac_sel, alu_or_mac,
           stall, wb_valid, wb_reg, wb_data, flag_we, flag_nz
  );

  modport master (
    output flush, req_valid, req_op, req_s, op_a, op_b, acc_lo, acc_hi,
           rd_lo, rd_hi, mac_out,
    input  req_ready, mac_op1, mac_op2, mac_acc, mac_sel, alu_or_mac,
           stall, wb_valid, wb_reg, wb_data, flag_we, flag_nz
  );
endinterface

// File: rtl/arm_mul_seq_acc64.sv
// 64-bit datapath for long multiplies: shifted partial-product accumulate,
// and the final conditional negate followed by the accumulate-operand add.
module arm_mul_acc64 (
  input  logic [63:0] acc_i,
  input  logic [31:0] pp_i,
  input  logic [1:0]  shift_i,
  input  logic        neg_i,
  input  logic        add_en_i,
  input  logic [63:0] addend_i,
  output logic [63:0] sum_o,
  output logic [63:0] fin_o
);
  logic [63:0] pp_ext;
  logic [63:0] pp_shifted;
  logic [63:0] acc_signed;

  always_comb begin
    pp_ext = {32'd0, pp_i};
    case (shift_i)
      2'd0:    pp_shifted = pp_ext;
      2'd1:    pp_shifted = pp_ext << 16;
      default: pp_shifted = pp_ext << 32;
    endcase
    sum_o      = acc_i + pp_shifted;
    acc_signed = neg_i ? (~acc_i + 64'd1) : acc_i;
    fin_o      = acc_signed + (add_en_i ? addend_i : 64'd0);
  end
endmodule

// File: rtl/arm_mul_seq.sv
// Execute-stage multiply sequencer: short ops take one MAC pass, long ops are
// built from four 16x16 MAC passes summed in a 64-bit accumulator.
module arm_mul_seq
  import arm_mul_seq_pkg::*;
#(
  parameter bit FAST_SHORT = 1'b1,
  parameter bit LONG_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_b,
  arm_mul_seq_if.slave bus
);
  mul_state_t  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        s_q, s_d;
  logic        neg_q, neg_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
  logic [3:0]  rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic [63:0] res_q, res_d;

  logic        accept;
  logic [1:0]  shift_sel;
  logic [63:0] sum64, fin64, addend64;

  assign accept = bus.req_valid && (state_q == IDLE) && !bus.flush &&
                  is_legal(bus.req_op) && (LONG_EN || !is_long(bus.req_op));
  // MLA routed through the long path only contributes Rn to the low word.
  assign addend64 = is_long(op_q) ? {acc_hi_q, acc_lo_q} : {32'd0, acc_lo_q};

  arm_mul_acc64 u_acc64 (
    .acc_i    (res_q),
    .pp_i     (bus.mac_out),
    .shift_i  (shift_sel),
    .neg_i    (neg_q),
    .add_en_i (is_acc(op_q)),
    .addend_i (addend64),
    .sum_o    (sum64),
    .fin_o    (fin64)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    s_d      = s_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    rd_lo_d  = rd_lo_q;
    rd_hi_d  = rd_hi_q;
    res_d    = res_q;
    shift_sel      = 2'd0;
    bus.req_ready  = (state_q == IDLE);
    bus.stall      = (state_q != IDLE);
    bus.mac_op1    = 32'd0;
    bus.mac_op2    = 32'd0;
    bus.mac_acc    = 32'd0;
    bus.mac_sel    = 1'b0;
    bus.alu_or_mac = 1'b1;
    bus.wb_valid   = 1'b0;
    bus.wb_reg     = 4'd0;
    bus.wb_data    = 32'd0;
    bus.flag_we    = 1'b0;
    bus.flag_nz    = 2'b00;

    case (state_q)
      IDLE: if (accept) begin
        op_d     = bus.req_op;
        s_d      = bus.req_s;
        neg_d    = is_signed(bus.req_op) && (bus.op_a[31] ^ bus.op_b[31]);
        a_d      = is_signed(bus.req_op) ? mag32(bus.op_a) : bus.op_a;
        b_d      = is_signed(bus.req_op) ? mag32(bus.op_b) : bus.op_b;
        acc_lo_d = bus.acc_lo;
        acc_hi_d = bus.acc_hi;
        rd_lo_d  = bus.rd_lo;
        rd_hi_d  = bus.rd_hi;
        res_d    = 64'd0;
        state_d  = (is_long(bus.req_op) || !FAST_SHORT) ? PP0 : SHORT;
      end
      SHORT: begin
        bus.alu_or_mac = 1'b0;
        bus.mac_op1    = a_q;
        bus.mac_op2    = b_q;
        bus.mac_acc    = acc_lo_q;
        bus.mac_sel    = (op_q == MLA);
        res_d          = {32'd0, bus.mac_out};
        state_d        = WB_LO;
      end
      PP0, PP1, PP2, PP3: begin
        bus.alu_or_mac = 1'b0;
        bus.mac_op1 = {16'd0, (state_q == PP2 || state_q == PP3) ? a_q[31:16] : a_q[15:0]};
        bus.mac_op2 = {16'd0, (state_q == PP1 || state_q == PP3) ? b_q[31:16] : b_q[15:0]};
        shift_sel   = (state_q == PP0) ? 2'd0 : (state_q == PP3) ? 2'd2 : 2'd1;
        res_d       = sum64;
        state_d     = (state_q == PP0) ? PP1 : (state_q == PP1) ? PP2 :
                      (state_q == PP2) ? PP3 : FIN;
      end
      FIN: begin
        res_d   = fin64;
        state_d = WB_LO;
      end
      WB_LO: begin
        bus.wb_valid = 1'b1;
        bus.wb_reg   = rd_lo_q;
        bus.wb_data  = res_q[31:0];
        if (is_long(op_q)) begin
          state_d = WB_HI;
        end else begin
          bus.flag_we = s_q;
          bus.flag_nz = {res_q[31], res_q[31:0] == 32'd0};
          state_d     = IDLE;
        end
      end
      WB_HI: begin
        bus.wb_valid = 1'b1;
        bus.wb_reg   = rd_hi_q;
        bus.wb_data  = res_q[63:32];
        bus.flag_we  = s_q;
        bus.flag_nz  = {res_q[63], res_q == 64'd0};
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush kills whatever strobe this cycle would have produced.
    if (bus.flush) begin
      state_d      = IDLE;
      bus.wb_valid = 1'b0;
      bus.flag_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      s_q      <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_lo_q <= 32'd0;
      acc_hi_q <= 32'd0;
      rd_lo_q  <= 4'd0;
      rd_hi_q  <= 4'd0;
      res_q    <= 64'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      s_q      <= s_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      rd_lo_q  <= rd_lo_d;
      rd_hi_q  <= rd_hi_d;
      res_q    <= res_d;
    end
  end
endmodule
